product_bcd_converter: RTL and testbench

//  Downstream stage of the 8x8 signed multiplier. Captures the 16-bit two's-complement

---
 rtl/product_bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/product_bcd_converter.sv | 120 ++++++++++++
 tb/tb_product_bcd_converter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/product_bcd_pkg.sv
// Shared definitions for the product-to-BCD conversion stage.
//   conv_state_t : converter FSM encoding
//   PROD_WIDTH   : default product width (two's complement)
//   BCD_DIGITS   : default number of magnitude digits
//   CNT_W        : shift counter width for the default product width
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    localparam int PROD_WIDTH = 16;
    localparam int BCD_DIGITS = 5;
    localparam int CNT_W      = $clog2(PROD_WIDTH);

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
//   digit_in  : current BCD digit
//   digit_out : corrected digit, ready to be shifted
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/product_bcd_converter.sv
// Converts a captured two's-complement multiplier product into sign plus
// magnitude BCD, one bit per clock, for the decimal display path.
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   Start   : conversion request, honoured only while idle
//   Product : signed product, captured on the accepted Start cycle
//   Busy    : conversion in progress (cycle after acceptance through DONE)
//   Done    : one-cycle pulse, coincides with Bcd/Neg taking the new result
//   Neg     : sign of the last converted product
//   Bcd     : magnitude digits, [3:0] = ones
//
// state | meaning
// IDLE  | waiting for Start, work reg loads Product on acceptance
// ABS   | capture sign, replace work with its magnitude, clear accumulator
// SHIFT | one adjust-and-shift step per cycle, WIDTH steps in total
// DONE  | result presented, Done high for this cycle, back to IDLE
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = PROD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Product,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Neg,
    output logic [4*DIGITS-1:0]   Bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    conv_state_t       state, state_next;
    logic [WIDTH-1:0]  work;
    logic [BW-1:0]     bcd_acc;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_shift;
    logic [CW-1:0]     cnt;
    logic              neg_next;
    logic              last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_acc[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // Top bit of the corrected accumulator drops off; the digit-count
    // constraint guarantees it is never set for an in-range magnitude.
    assign bcd_shift  = BW'({bcd_adj, work[WIDTH-1]});
    assign last_shift = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = ABS;
            ABS:     state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            work     <= '0;
            bcd_acc  <= '0;
            cnt      <= '0;
            neg_next <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Neg      <= 1'b0;
            Bcd      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        work <= Product;
                        Busy <= 1'b1;
                    end
                end
                ABS: begin
                    // Magnitude kept as unsigned WIDTH bits, so the most
                    // negative product negates to itself and reads correctly.
                    neg_next <= work[WIDTH-1];
                    work     <= work[WIDTH-1] ? (~work + WIDTH'(1)) : work;
                    bcd_acc  <= '0;
                    cnt      <= '0;
                end
                SHIFT: begin
                    bcd_acc <= bcd_shift;
                    work    <= work << 1;
                    cnt     <= cnt + CW'(1);
                    // Result registers load with the final step so they are
                    // valid in the same cycle that Done is high.
                    if (last_shift) begin
                        Bcd  <= bcd_shift;
                        Neg  <= neg_next;
                        Done <= 1'b1;
                    end
                end
                DONE: begin
                    Done <= 1'b0;
                    Busy <= 1'b0;
                end
                default: begin
                    Done <= 1'b0;
                    Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [15:0] Product;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] Bcd;

    int errors = 0;
    int checks = 0;

    product_bcd_converter dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done),
        .Neg     (Neg),
        .Bcd     (Bcd)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start is presented during cycle 0; loop index cyc counts cycles after that.
    task automatic run_conv(input string tag, input logic [15:0] p, input int alt_cyc,
                            input logic [15:0] alt_p, input logic [19:0] exp_bcd,
                            input logic exp_neg);
        int done_cyc;
        int n_done;
        int busy_bad;
        int hold_bad;
        logic [19:0] prev_bcd;
        logic        prev_neg;
        done_cyc = -1;
        n_done   = 0;
        busy_bad = 0;
        hold_bad = 0;
        @(negedge Clk);
        prev_bcd = Bcd;
        prev_neg = Neg;
        Start    = 1'b1;
        Product  = p;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge Clk);
            if (Done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (Busy !== (cyc <= 18)) busy_bad++;
            if (cyc < 18 && (Bcd !== prev_bcd || Neg !== prev_neg)) hold_bad++;
            Start   = (cyc == alt_cyc);
            Product = (cyc == alt_cyc) ? alt_p : 16'($urandom);
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'd18);
        chk({tag, " done_count"}, 32'(n_done), 32'd1);
        chk({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, " hold_prev"}, 32'(hold_bad), 32'd0);
        chk({tag, " bcd"}, 32'(Bcd), 32'(exp_bcd));
        chk({tag, " neg"}, 32'(Neg), 32'(exp_neg));
    endtask

    initial begin
        int d_cyc [0:3];
        int n_done;
        int n_low;
        int low_pairs;
        int seen_done;
        logic prev_low;

        Reset_n = 1'b0;
        Start   = 1'b0;
        Product = 16'h0000;
        repeat (3) @(negedge Clk);
        chk("rst busy", 32'(Busy), 32'd0);
        chk("rst done", 32'(Done), 32'd0);
        chk("rst neg",  32'(Neg),  32'd0);
        chk("rst bcd",  32'(Bcd),  32'd0);
        Reset_n = 1'b1;

        run_conv("zero",    16'h0000, -1, 16'h0000, 20'h00000, 1'b0);
        run_conv("neg21",   16'hFFEB, -1, 16'h0000, 20'h00021, 1'b1);
        run_conv("p16384",  16'h4000, -1, 16'h0000, 20'h16384, 1'b0);
        run_conv("min",     16'h8000, -1, 16'h0000, 20'h32768, 1'b1);
        run_conv("max",     16'h7FFF, -1, 16'h0000, 20'h32767, 1'b0);
        run_conv("ignore",  16'h0064,  5, 16'h0005, 20'h00100, 1'b0);

        // Reset in the middle of a conversion.
        @(negedge Clk);
        Start   = 1'b1;
        Product = 16'hFFFF;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        chk("abort bcd",  32'(Bcd),  32'd0);
        chk("abort neg",  32'(Neg),  32'd0);
        seen_done = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Done) seen_done++;
        end
        Reset_n = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (Done || Busy) seen_done++;
        end
        chk("abort quiet", 32'(seen_done), 32'd0);
        run_conv("after_rst", 16'hFFFF, -1, 16'h0000, 20'h00001, 1'b1);

        // Start held high: back-to-back conversions.
        for (int i = 0; i < 4; i++) d_cyc[i] = -1;
        n_done    = 0;
        n_low     = 0;
        low_pairs = 0;
        prev_low  = 1'b0;
        @(negedge Clk);
        Start   = 1'b1;
        Product = 16'd42;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge Clk);
            if (Done) begin
                if (n_done < 4) d_cyc[n_done] = cyc;
                n_done++;
            end
            if (!Busy) begin
                n_low++;
                if (prev_low) low_pairs++;
            end
            prev_low = !Busy;
        end
        Start = 1'b0;
        chk("held done0", 32'(d_cyc[0]), 32'd18);
        chk("held done1", 32'(d_cyc[1]), 32'd37);
        chk("held done2", 32'(d_cyc[2]), 32'd56);
        chk("held done_count", 32'(n_done), 32'd3);
        chk("held busy_low", 32'(n_low), 32'd3);
        chk("held low_pairs", 32'(low_pairs), 32'd0);
        repeat (25) @(negedge Clk);
        chk("held bcd", 32'(Bcd), 32'h00042);
        chk("held neg", 32'(Neg), 32'd0);
        chk("held idle", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
